// File: rtl/ip_pkt_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ip_pkt_pkg : Ethernet/IPv4/UDP framing constants and TX state type | rev 1.0
// ----------------------------------------------------------------------------
package ip_pkt_pkg;

  localparam int ETH_HDR_BYTES       = 14;
  localparam int IP_HDR_BYTES        = 20;
  localparam int UDP_HDR_BYTES       = 8;
  localparam int ETH_MIN_FRAME_BYTES = 60;
  localparam int IP_HDR_WORDS        = IP_HDR_BYTES / 2;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  IP_TTL_DEFAULT = 8'h40;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CSUM      = 3'd1,
    ST_SEND_ETH  = 3'd2,
    ST_SEND_IP   = 3'd3,
    ST_SEND_UDP  = 3'd4,
    ST_SEND_DATA = 3'd5,
    ST_SEND_PAD  = 3'd6
  } tx_state_t;

  // Bytes on the wire before the FCS, including zero padding to the minimum.
  function automatic int frame_bytes(input int payload_bytes);
    int raw;
    raw = ETH_HDR_BYTES + IP_HDR_BYTES + UDP_HDR_BYTES + payload_bytes;
    return (raw < ETH_MIN_FRAME_BYTES) ? ETH_MIN_FRAME_BYTES : raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_sync_reset.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_sync_reset : up counter with synchronous reset and clear | rev 1.0
// ----------------------------------------------------------------------------
module counter_sync_reset #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ip_checksum_serial.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ip_checksum_serial : word-serial IPv4 ones-complement checksum | rev 1.0
// ----------------------------------------------------------------------------
module ip_checksum_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        word_valid,
  input  logic [15:0] word,
  output logic [15:0] csum
);

  logic [19:0] acc;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (word_valid) begin
      acc <= acc + {4'd0, word};
    end
  end

  // Twenty bits hold ten full-scale words; two folds always leave no carry.
  always_comb begin
    fold1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
    fold2 = fold1[15:0] + {15'd0, fold1[16]};
    csum  = ~fold2;
  end

endmodule
`default_nettype wire

// File: rtl/ip_packet_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ip_packet_tx : builds and streams one Ethernet/IPv4/UDP frame per start | rev 1.0
// ----------------------------------------------------------------------------
module ip_packet_tx
  import ip_pkt_pkg::*;
#(
  parameter int USER_DATA_BYTES = 2,
  parameter int COUNTER_WIDTH   = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [31:0]                  ACCELERATOR_IP_ADDRESS,
  input  logic [47:0]                  ACCELERATOR_MAC_ADDRESS,
  input  logic [15:0]                  ACCELERATOR_UDP_PORT,
  input  logic [31:0]                  DST_IP_ADDRESS,
  input  logic [47:0]                  DST_MAC_ADDRESS,
  input  logic [15:0]                  DST_UDP_PORT,
  input  logic [USER_DATA_BYTES*8-1:0] PAYLOAD,
  input  logic                         TX_START,
  output logic                         TX_BUSY,
  output logic                         TX_DONE,
  output logic [7:0]                   MAC_DATA_IN,
  output logic                         MAC_DATA_VALID,
  input  logic                         MAC_DATA_READY,
  output logic                         MAC_DATA_LAST
);

  localparam int HDR_BYTES    = ETH_HDR_BYTES + IP_HDR_BYTES + UDP_HDR_BYTES;
  localparam int FRAME_BYTES  = frame_bytes(USER_DATA_BYTES);
  localparam int HDR_BITS     = HDR_BYTES * 8;
  localparam int PAYLOAD_BITS = USER_DATA_BYTES * 8;
  localparam int IPW_BITS     = IP_HDR_WORDS * 16;

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;
  localparam cnt_t CSUM_DONE = cnt_t'(IP_HDR_WORDS);
  localparam cnt_t ETH_END   = cnt_t'(ETH_HDR_BYTES);
  localparam cnt_t IP_END    = cnt_t'(ETH_HDR_BYTES + IP_HDR_BYTES);
  localparam cnt_t UDP_END   = cnt_t'(HDR_BYTES);
  localparam cnt_t DATA_END  = cnt_t'(HDR_BYTES + USER_DATA_BYTES);
  localparam cnt_t LAST_IDX  = cnt_t'(FRAME_BYTES - 1);

  localparam logic [15:0] IP_TOTAL_LEN = 16'(IP_HDR_BYTES + UDP_HDR_BYTES + USER_DATA_BYTES);
  localparam logic [15:0] UDP_LEN      = 16'(UDP_HDR_BYTES + USER_DATA_BYTES);

  tx_state_t                 state;
  logic [47:0]               dst_mac_q, src_mac_q;
  logic [31:0]               dst_ip_q, src_ip_q;
  logic [15:0]               dst_port_q, src_port_q;
  logic [PAYLOAD_BITS-1:0]   payload_q;
  logic [15:0]               id_cnt;
  logic [15:0]               csum_q;

  cnt_t                      cnt;
  cnt_t                      byte_sel;
  logic                      cnt_clear, cnt_en, handshake;
  logic                      ck_clear, ck_valid;
  logic [15:0]               ck_word, ck_out;
  logic [HDR_BITS-1:0]       hdr, hdr_shift;
  logic [PAYLOAD_BITS-1:0]   pay_shift;
  logic [IPW_BITS-1:0]       ip_words, ipw_shift;
  logic [7:0]                next_byte;
  tx_state_t                 next_state;

  assign hdr = {dst_mac_q, src_mac_q, ETHERTYPE_IPV4,
                IP_VER_IHL, 8'h00, IP_TOTAL_LEN, id_cnt, IP_FLAGS_DF,
                IP_TTL_DEFAULT, IP_PROTO_UDP, csum_q, src_ip_q, dst_ip_q,
                src_port_q, dst_port_q, UDP_LEN, 16'h0000};

  // Checksum input is the IPv4 header with its checksum field zeroed.
  assign ip_words = {IP_VER_IHL, 8'h00, IP_TOTAL_LEN, id_cnt, IP_FLAGS_DF,
                     IP_TTL_DEFAULT, IP_PROTO_UDP, 16'h0000, src_ip_q, dst_ip_q};

  assign handshake = MAC_DATA_VALID & MAC_DATA_READY;
  assign cnt_clear = (state == ST_IDLE) || ((state == ST_CSUM) && (cnt == CSUM_DONE));
  assign cnt_en    = (state == ST_CSUM) || handshake;
  assign ck_clear  = (state == ST_IDLE);
  assign ck_valid  = (state == ST_CSUM) && (cnt < CSUM_DONE);
  assign ipw_shift = ip_words << {cnt, 4'b0000};
  assign ck_word   = ipw_shift[IPW_BITS-1 -: 16];

  // The output register is always loaded with the byte after the one on the bus.
  assign byte_sel  = (state == ST_CSUM) ? '0 : cnt + cnt_t'(1);

  always_comb begin
    hdr_shift  = hdr << {byte_sel, 3'b000};
    pay_shift  = payload_q << {byte_sel - UDP_END, 3'b000};
    next_byte  = 8'h00;
    next_state = ST_SEND_PAD;
    if (byte_sel < ETH_END) begin
      next_state = ST_SEND_ETH;
      next_byte  = hdr_shift[HDR_BITS-1 -: 8];
    end else if (byte_sel < IP_END) begin
      next_state = ST_SEND_IP;
      next_byte  = hdr_shift[HDR_BITS-1 -: 8];
    end else if (byte_sel < UDP_END) begin
      next_state = ST_SEND_UDP;
      next_byte  = hdr_shift[HDR_BITS-1 -: 8];
    end else if (byte_sel < DATA_END) begin
      next_state = ST_SEND_DATA;
      next_byte  = pay_shift[PAYLOAD_BITS-1 -: 8];
    end
  end

  counter_sync_reset #(
    .WIDTH  (COUNTER_WIDTH)
  ) u_byte_cnt (
    .clk    (ACLK),
    .rst    (ARESET),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (cnt)
  );

  ip_checksum_serial u_csum (
    .clk        (ACLK),
    .rst        (ARESET),
    .clear      (ck_clear),
    .word_valid (ck_valid),
    .word       (ck_word),
    .csum       (ck_out)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state          <= ST_IDLE;
      TX_BUSY        <= 1'b0;
      TX_DONE        <= 1'b0;
      MAC_DATA_IN    <= 8'h00;
      MAC_DATA_VALID <= 1'b0;
      MAC_DATA_LAST  <= 1'b0;
      id_cnt         <= 16'h0000;
      csum_q         <= 16'h0000;
      dst_mac_q      <= '0;
      src_mac_q      <= '0;
      dst_ip_q       <= '0;
      src_ip_q       <= '0;
      dst_port_q     <= '0;
      src_port_q     <= '0;
      payload_q      <= '0;
    end else begin
      TX_DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (TX_START) begin
            dst_mac_q  <= DST_MAC_ADDRESS;
            src_mac_q  <= ACCELERATOR_MAC_ADDRESS;
            dst_ip_q   <= DST_IP_ADDRESS;
            src_ip_q   <= ACCELERATOR_IP_ADDRESS;
            dst_port_q <= DST_UDP_PORT;
            src_port_q <= ACCELERATOR_UDP_PORT;
            payload_q  <= PAYLOAD;
            TX_BUSY    <= 1'b1;
            state      <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (cnt == CSUM_DONE) begin
            csum_q         <= ck_out;
            MAC_DATA_IN    <= next_byte;
            MAC_DATA_VALID <= 1'b1;
            MAC_DATA_LAST  <= 1'b0;
            state          <= next_state;
          end
        end
        default: begin
          if (handshake) begin
            if (cnt == LAST_IDX) begin
              MAC_DATA_IN    <= 8'h00;
              MAC_DATA_VALID <= 1'b0;
              MAC_DATA_LAST  <= 1'b0;
              TX_BUSY        <= 1'b0;
              TX_DONE        <= 1'b1;
              id_cnt         <= id_cnt + 16'd1;
              state          <= ST_IDLE;
            end else begin
              MAC_DATA_IN    <= next_byte;
              MAC_DATA_LAST  <= (byte_sel == LAST_IDX);
              state          <= next_state;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ip_packet_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ip_packet_tx : streams frames from two configurations and compares them
// with a byte-level frame model built from the protocol field layout | rev 1.0
// ----------------------------------------------------------------------------
module tb_ip_packet_tx;

  typedef byte unsigned bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  src_ip   = 32'hC0A8010A;
  logic [47:0]  src_mac  = 48'h0200_00AB_CDEF;
  logic [15:0]  src_port = 16'd5000;
  logic [31:0]  dst_ip   = 32'hC0A80101;
  logic [47:0]  dst_mac  = 48'h0211_2233_4455;
  logic [15:0]  dst_port = 16'd6000;
  logic [15:0]  payload_a = 16'hA55A;
  logic [159:0] payload_b = '0;

  logic start_a = 1'b0, start_b = 1'b0, ready_a = 1'b0, ready_b = 1'b0;
  logic busy_a, done_a, valid_a, last_a, busy_b, done_b, valid_b, last_b;
  logic [7:0] data_a, data_b;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_id_a = 16'h0000;
  logic [15:0] exp_id_b = 16'h0000;
  int done_cnt_a = 0;

  always @(negedge clk) if (done_a === 1'b1) done_cnt_a++;

  ip_packet_tx #(.USER_DATA_BYTES(2), .COUNTER_WIDTH(16)) dut_a (
    .ACLK(clk), .ARESET(rst),
    .ACCELERATOR_IP_ADDRESS(src_ip), .ACCELERATOR_MAC_ADDRESS(src_mac),
    .ACCELERATOR_UDP_PORT(src_port), .DST_IP_ADDRESS(dst_ip),
    .DST_MAC_ADDRESS(dst_mac), .DST_UDP_PORT(dst_port), .PAYLOAD(payload_a),
    .TX_START(start_a), .TX_BUSY(busy_a), .TX_DONE(done_a),
    .MAC_DATA_IN(data_a), .MAC_DATA_VALID(valid_a),
    .MAC_DATA_READY(ready_a), .MAC_DATA_LAST(last_a)
  );

  ip_packet_tx #(.USER_DATA_BYTES(20), .COUNTER_WIDTH(16)) dut_b (
    .ACLK(clk), .ARESET(rst),
    .ACCELERATOR_IP_ADDRESS(src_ip), .ACCELERATOR_MAC_ADDRESS(src_mac),
    .ACCELERATOR_UDP_PORT(src_port), .DST_IP_ADDRESS(dst_ip),
    .DST_MAC_ADDRESS(dst_mac), .DST_UDP_PORT(dst_port), .PAYLOAD(payload_b),
    .TX_START(start_b), .TX_BUSY(busy_b), .TX_DONE(done_b),
    .MAC_DATA_IN(data_b), .MAC_DATA_VALID(valid_b),
    .MAC_DATA_READY(ready_b), .MAC_DATA_LAST(last_b)
  );

  // Reference frame: fields laid out in wire order, checksum by folded 32-bit sum.
  function automatic bq_t build_frame(input int n, input logic [47:0] dmac,
                                      input logic [31:0] dip, input logic [15:0] dport,
                                      input logic [15:0] id, input logic [159:0] pl);
    bq_t f;
    int w[10];
    int sum, val;
    f = {};
    for (int k = 0; k < 6; k++) f.push_back(8'(dmac >> (40 - 8 * k)));
    for (int k = 0; k < 6; k++) f.push_back(8'(src_mac >> (40 - 8 * k)));
    f.push_back(8'h08); f.push_back(8'h00);
    w = '{32'h4500, 28 + n, int'(id), 32'h4000, 32'h4011, 0,
          int'(src_ip[31:16]), int'(src_ip[15:0]), int'(dip[31:16]), int'(dip[15:0])};
    sum = 0;
    foreach (w[k]) sum += w[k];
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    sum = ~sum & 32'hFFFF;
    for (int k = 0; k < 10; k++) begin
      val = (k == 5) ? sum : w[k];
      f.push_back(8'(val >> 8)); f.push_back(8'(val));
    end
    f.push_back(8'(src_port >> 8)); f.push_back(8'(src_port));
    f.push_back(8'(dport >> 8));    f.push_back(8'(dport));
    f.push_back(8'((8 + n) >> 8));  f.push_back(8'(8 + n));
    f.push_back(8'h00); f.push_back(8'h00);
    for (int k = 0; k < n; k++) f.push_back(8'(pl >> (8 * (n - 1 - k))));
    while (f.size() < 60) f.push_back(8'h00);
    return f;
  endfunction

  function automatic int first_diff(input bq_t got, input bq_t exp);
    if (got.size() != exp.size()) return (got.size() < exp.size()) ? got.size() : exp.size();
    foreach (exp[i]) if (got[i] != exp[i]) return i;
    return -1;
  endfunction

  task automatic rand_fields();
    dst_mac   = {16'($urandom), $urandom};
    dst_ip    = $urandom;
    dst_port  = 16'($urandom);
    payload_a = 16'($urandom);
    payload_b = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  // Collects handshaken bytes; returns at the negedge before the final accepted edge.
  task automatic capture(input bit sel, input int mode, input int stop_at, input bit poke,
                         output bq_t got, output int last_beat, output int last_cnt,
                         output bit done_ok);
    bit hold;
    logic [7:0] hold_data, d;
    logic v, l;
    bit rdy;
    hold = 1'b0; hold_data = 8'h00;
    got = {}; last_beat = -1; last_cnt = 0; done_ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      v = sel ? valid_b : valid_a;
      d = sel ? data_b : data_a;
      l = sel ? last_b : last_a;
      if (hold) begin
        checks++;
        if (v !== 1'b1 || d !== hold_data) begin
          failures++;
          $display("FAIL stall_hold beat=%0d got valid=%b data=%h expected valid=1 data=%h",
                   got.size(), v, d, hold_data);
        end
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((c % 2) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (sel) ready_b = rdy; else ready_a = rdy;
      if (!sel) start_a = poke && (got.size() == 20);
      if (v === 1'b1 && rdy) begin
        got.push_back(d);
        if (l === 1'b1) begin last_cnt++; last_beat = got.size() - 1; end
        hold = 1'b0;
        if (l === 1'b1 || got.size() == stop_at) begin done_ok = 1'b1; break; end
      end else begin
        hold = (v === 1'b1);
        hold_data = d;
      end
      if (got.size() > 100) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, done_a, valid_a, last_a, data_a} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs_a got %b expected 0", {busy_a, done_a, valid_a, last_a, data_a});
    end
    checks++;
    if ({busy_b, done_b, valid_b, last_b, data_b} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs_b got %b expected 0", {busy_b, done_b, valid_b, last_b, data_b});
    end
    rst = 1'b0;
    exp_id_a = 16'h0000; exp_id_b = 16'h0000;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bq_t got, exp;
    int lb, lc, lat, df;
    bit ok;
    dst_ip = 32'hC0A80101; dst_mac = {16'($urandom), $urandom};
    dst_port = 16'($urandom); payload_a = 16'($urandom);
    exp = build_frame(2, dst_mac, dst_ip, dst_port, exp_id_a, {144'd0, payload_a});
    ready_a = 1'b0;
    pulse_start(1'b0);
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL busy_after_start got %b expected 1", busy_a); end
    lat = 0;
    while (valid_a !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat != 11) begin failures++; $display("FAIL first_valid_latency got %0d expected 11", lat); end
    capture(1'b0, 0, -1, 1'b0, got, lb, lc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout got %0d beats expected 60", got.size()); end
    df = first_diff(got, exp);
    checks++;
    if (df >= 0) begin failures++; $display("FAIL basic_frame at byte %0d got %h expected %h (size %0d/%0d)", df, got[df], exp[df], got.size(), exp.size()); end
    checks++;
    if ({got[16], got[17], got[18], got[19]} !== 32'h001E_0000) begin
      failures++; $display("FAIL basic_len_id got %h expected 001e0000", {got[16], got[17], got[18], got[19]});
    end
    checks++;
    if ({got[24], got[25]} !== 16'hB773) begin
      failures++; $display("FAIL basic_checksum got %h expected b773", {got[24], got[25]});
    end
    checks++;
    if ({got[38], got[39]} !== 16'h000A) begin
      failures++; $display("FAIL basic_udp_len got %h expected 000a", {got[38], got[39]});
    end
    for (int i = 44; i < 60; i++) begin
      checks++;
      if (got[i] != 8'h00) begin failures++; $display("FAIL basic_pad byte %0d got %h expected 00", i, got[i]); end
    end
    checks++;
    if (lb != 59 || lc != 1) begin failures++; $display("FAIL basic_last got beat %0d count %0d expected beat 59 count 1", lb, lc); end
    @(negedge clk);
    checks++;
    if ({done_a, busy_a, valid_a} !== 3'b100) begin
      failures++; $display("FAIL basic_done got done/busy/valid=%b expected 100", {done_a, busy_a, valid_a});
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0) begin failures++; $display("FAIL basic_done_width got %b expected 0", done_a); end
    exp_id_a++;
  endtask

  task automatic test_ready_toggle();
    bq_t got, exp;
    int lb, lc, df;
    bit ok;
    exp = build_frame(2, dst_mac, dst_ip, dst_port, exp_id_a, {144'd0, payload_a});
    ready_a = 1'b0;
    pulse_start(1'b0);
    capture(1'b0, 1, -1, 1'b0, got, lb, lc, ok);
    checks++;
    if (!ok || got.size() != 60) begin failures++; $display("FAIL toggle_beats got %0d expected 60", got.size()); end
    df = first_diff(got, exp);
    checks++;
    if (df >= 0) begin failures++; $display("FAIL toggle_frame at byte %0d got %h expected %h", df, got[df], exp[df]); end
    checks++;
    if (lb != 59 || lc != 1) begin failures++; $display("FAIL toggle_last got beat %0d count %0d expected 59/1", lb, lc); end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b1) begin failures++; $display("FAIL toggle_done got %b expected 1", done_a); end
    exp_id_a++;
  endtask

  task automatic test_no_pad();
    bq_t got, exp;
    int lb, lc, df;
    bit ok;
    rand_fields();
    exp = build_frame(20, dst_mac, dst_ip, dst_port, exp_id_b, payload_b);
    ready_b = 1'b0;
    pulse_start(1'b1);
    capture(1'b1, 2, -1, 1'b0, got, lb, lc, ok);
    checks++;
    if (!ok || got.size() != 62) begin failures++; $display("FAIL nopad_beats got %0d expected 62", got.size()); end
    df = first_diff(got, exp);
    checks++;
    if (df >= 0) begin failures++; $display("FAIL nopad_frame at byte %0d got %h expected %h", df, got[df], exp[df]); end
    checks++;
    if ({got[16], got[17], got[38], got[39]} !== 32'h0030_001C) begin
      failures++; $display("FAIL nopad_lengths got %h expected 0030001c", {got[16], got[17], got[38], got[39]});
    end
    checks++;
    if (lb != 61 || lc != 1) begin failures++; $display("FAIL nopad_last got beat %0d count %0d expected 61/1", lb, lc); end
    @(negedge clk);
    checks++;
    if ({done_b, busy_b} !== 2'b10) begin failures++; $display("FAIL nopad_done got %b expected 10", {done_b, busy_b}); end
    exp_id_b++;
  endtask

  task automatic test_back_to_back();
    bq_t got, exp;
    int lb, lc, df, done0;
    bit ok, stray;
    done0 = done_cnt_a;
    for (int p = 0; p < 2; p++) begin
      rand_fields();
      exp = build_frame(2, dst_mac, dst_ip, dst_port, exp_id_a, {144'd0, payload_a});
      if (p == 0) pulse_start(1'b0);
      else begin start_a = 1'b1; @(negedge clk); start_a = 1'b0; end
      capture(1'b0, 2, -1, 1'b1, got, lb, lc, ok);
      df = first_diff(got, exp);
      checks++;
      if (!ok || df >= 0) begin failures++; $display("FAIL b2b_frame pkt %0d at byte %0d got %h expected %h", p, df, got[df], exp[df]); end
      checks++;
      if ({got[18], got[19]} !== exp_id_a) begin failures++; $display("FAIL b2b_id pkt %0d got %h expected %h", p, {got[18], got[19]}, exp_id_a); end
      @(negedge clk);
      checks++;
      if (done_a !== 1'b1) begin failures++; $display("FAIL b2b_done pkt %0d got %b expected 1", p, done_a); end
      exp_id_a++;
    end
    stray = 1'b0;
    repeat (20) begin @(negedge clk); if (valid_a !== 1'b0 || busy_a !== 1'b0) stray = 1'b1; end
    checks++;
    if (stray) begin failures++; $display("FAIL b2b_ignored_start got an extra packet expected idle"); end
    checks++;
    if (done_cnt_a - done0 != 2) begin failures++; $display("FAIL b2b_done_count got %0d expected 2", done_cnt_a - done0); end
  endtask

  task automatic test_reset_mid();
    bq_t got, exp;
    int lb, lc, df;
    bit ok;
    rand_fields();
    pulse_start(1'b0);
    capture(1'b0, 0, 30, 1'b0, got, lb, lc, ok);
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (!ok || lc != 0 || last_a !== 1'b0) begin failures++; $display("FAIL midrst_no_last got last count %0d last=%b expected 0", lc, last_a); end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({valid_a, busy_a, last_a} !== 3'b000) begin
      failures++; $display("FAIL midrst_idle got valid/busy/last=%b expected 000", {valid_a, busy_a, last_a});
    end
    exp_id_a = 16'h0000;
    rand_fields();
    exp = build_frame(2, dst_mac, dst_ip, dst_port, exp_id_a, {144'd0, payload_a});
    pulse_start(1'b0);
    capture(1'b0, 2, -1, 1'b0, got, lb, lc, ok);
    df = first_diff(got, exp);
    checks++;
    if (!ok || df >= 0) begin failures++; $display("FAIL midrst_next_frame at byte %0d got %h expected %h", df, got[df], exp[df]); end
    checks++;
    if ({got[18], got[19]} !== 16'h0000) begin failures++; $display("FAIL midrst_id got %h expected 0000", {got[18], got[19]}); end
    @(negedge clk);
    exp_id_a++;
  endtask

  task automatic test_id_wrap();
    bq_t got, exp;
    int lb, lc, df;
    bit ok;
    @(negedge clk);
    force dut_a.id_cnt = 16'hFFFF;
    @(negedge clk);
    release dut_a.id_cnt;
    exp_id_a = 16'hFFFF;
    for (int p = 0; p < 2; p++) begin
      rand_fields();
      exp = build_frame(2, dst_mac, dst_ip, dst_port, exp_id_a, {144'd0, payload_a});
      pulse_start(1'b0);
      capture(1'b0, 2, -1, 1'b0, got, lb, lc, ok);
      df = first_diff(got, exp);
      checks++;
      if (!ok || df >= 0) begin failures++; $display("FAIL wrap_frame pkt %0d at byte %0d got %h expected %h", p, df, got[df], exp[df]); end
      checks++;
      if ({got[18], got[19]} !== exp_id_a) begin failures++; $display("FAIL wrap_id pkt %0d got %h expected %h", p, {got[18], got[19]}, exp_id_a); end
      @(negedge clk);
      exp_id_a++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_no_pad();
    test_back_to_back();
    test_reset_mid();
    test_id_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ip_packet_tx.md
Name: ip_packet_tx

Overview:
Transmit-side counterpart of the accelerator's UDP/IPv4 receive path. On a start pulse it latches the destination addresses and a fixed-size result payload. It computes the IPv4 header checksum, then streams a complete Ethernet/IPv4/UDP frame, one byte per beat, into the MAC TX AXI-stream interface. The MAC appends the FCS; this block zero-pads the frame to the Ethernet minimum.

Parameters:
USER_DATA_BYTES, 2, UDP payload length in bytes (result byte + metadata byte); legal range 1..1472
COUNTER_WIDTH, 16, width of the byte/state counter

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous, active-high reset
ACCELERATOR_IP_ADDRESS  in  [0:31]  source IP
ACCELERATOR_MAC_ADDRESS  in  [0:47]  source MAC
ACCELERATOR_UDP_PORT  in  [0:15]  source UDP port
DST_IP_ADDRESS  in  [0:31]  destination IP, latched on TX_START
DST_MAC_ADDRESS  in  [0:47]  destination MAC, latched on TX_START
DST_UDP_PORT  in  [0:15]  destination port, latched on TX_START
PAYLOAD  in  [0:USER_DATA_BYTES*8-1]  payload; bits [0:7] are sent first; latched on TX_START
TX_START  in  1  request to send one packet
TX_BUSY  out  1  high from accepted start until the last beat is accepted
TX_DONE  out  1  one-cycle pulse after the last beat is accepted
MAC_DATA_IN  out  [7:0]  byte to MAC
MAC_DATA_VALID  out  1  AXI-S tvalid
MAC_DATA_READY  in  1  AXI-S tready
MAC_DATA_LAST  out  1  AXI-S tlast

Behaviour:
- Reset (ARESET=1 at a clock edge): state goes to IDLE; all outputs are 0; the IP identification counter is cleared to 0.
- Reset mid-packet: the same values apply on the next cycle. No LAST is emitted; the MAC drops or flags the truncated frame. This is accepted behaviour.
- Byte order: every header field is sent in network order, MSB byte first.

Frame content, byte index i:
- Ethernet header (14 bytes): dst MAC, src MAC, ethertype 0x0800.
- IPv4 header (20 bytes), in order:
  - 0x45
  - 0x00
  - total length = 28+USER_DATA_BYTES
  - identification = ID counter
  - flags/fragment offset 0x4000
  - TTL 0x40
  - protocol 0x11
  - header checksum
  - src IP
  - dst IP
- UDP header (8 bytes): src port, dst port, length = 8+USER_DATA_BYTES, checksum 0x0000.
- Payload: USER_DATA_BYTES bytes.
- Padding: 0x00 bytes until the frame reaches 60 bytes. Padding is never counted in the IP or UDP length fields.

State machine:
- IDLE
  - TX_START=1 latches the destination addresses and PAYLOAD, asserts TX_BUSY, and goes to CSUM.
  - TX_START while not in IDLE is ignored; there is no queueing.
- CSUM
  - Feeds the ten 16-bit header words, one per cycle, into a ones-complement sum; the checksum word is fed as 0.
  - The accumulator is 20 bits. Carries are folded twice, then the result is inverted.
  - Exits after 10 cycles to SEND_ETH.
- SEND_ETH, SEND_IP, SEND_UDP, SEND_DATA, SEND_PAD
  - MAC_DATA_VALID is held at 1.
  - The byte counter advances only on VALID&&READY. MAC_DATA_IN stays stable while READY=0.
  - Each state exits on the handshake of its final byte. SEND_PAD is skipped if 42+USER_DATA_BYTES >= 60.
- MAC_DATA_LAST is 1 only together with the final frame byte (index max(60, 42+N)-1).
- On acceptance of that byte: TX_DONE pulses for 1 cycle, TX_BUSY drops, the ID counter increments (wraps 0xFFFF->0), and the state returns to IDLE.
- Latency: with TX_START sampled at edge k, the first VALID is asserted after edge k+11. A new TX_START is accepted in the cycle TX_DONE is high.
- READY held low indefinitely: the block holds the current byte with no timeout.

Decomposition:
- Shared package ip_pkt_pkg, also used by the receive path:
  - header size constants (14/20/8)
  - ETHERTYPE_IPV4, IP_PROTO_UDP, IP_TTL_DEFAULT
  - ETH_MIN_FRAME_BYTES=60
  - state enum typedef
- Sub-module ip_checksum_serial:
  - ports: clear, word-valid, 16-bit word in, 16-bit folded/inverted checksum out
  - reused later for RX header verification
- The byte counter reuses the existing counter_sync_reset.

Test Plan:
1. N=2, src 192.168.1.10, dst 192.168.1.1, first packet after reset, READY=1 -> 60 beats:
   - IP bytes 16-17 = 0x001E; ID = 0x0000; checksum bytes 24-25 = 0xB773
   - UDP length 0x000A; bytes 44..59 = 0x00; LAST only on beat 59; TX_DONE one cycle later.
2. Same stimulus, READY toggled 1-0-1 per cycle -> identical byte sequence; MAC_DATA_IN stable whenever VALID=1 and READY=0; 60 handshakes total.
3. N=20 -> 62 beats, no padding; total length 0x0030; UDP length 0x001C; LAST on beat 61.
4. Two back-to-back packets, with TX_START also pulsed mid-packet -> the mid-packet start is ignored; the second packet has ID 0x0001; exactly 2 TX_DONE pulses.
5. ARESET asserted at beat 30 -> next cycle VALID=0, BUSY=0, LAST never asserted; the following packet starts with ID 0x0000 and a correct header.
6. ID counter preset to 0xFFFF via 65535 sent packets (or force) -> the next packet uses 0xFFFF and the following one uses 0x0000; checksums are correct for both.
